// File: rtl/food_manager.sv
// Food slot manager for the snake playfield: detects the head landing on food, scores it,
// and respawns the eaten slot at a pseudo-random free cell chosen by a free-running LFSR.
module food_manager #(
  parameter int unsigned NUM_FOOD  = 3,
  parameter int unsigned X_W       = 6,
  parameter int unsigned Y_W       = 5,
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned TICK_DIV  = 250000,
  parameter int unsigned INIT_X    = 24,
  parameter int unsigned INIT_Y    = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned SCORE_W   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pause,
  input  logic [X_W-1:0]          head_x,
  input  logic [Y_W-1:0]          head_y,
  output logic [NUM_FOOD*X_W-1:0] food_x,
  output logic [NUM_FOOD*Y_W-1:0] food_y,
  output logic [NUM_FOOD-1:0]     food_valid,
  output logic                    grow,
  output logic [2:0]              eaten_idx,
  output logic [SCORE_W-1:0]      score
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickMax = CntW'(TICK_DIV - 1);
  localparam logic [X_W-1:0] XMax = X_W'(GRID_W - 2);
  localparam logic [Y_W-1:0] YMax = Y_W'(GRID_H - 2);

  typedef enum logic [0:0] {StIdle, StRespawn} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 pending_q;
  logic                 grow_q;
  logic [2:0]           eaten_idx_q;
  logic [SCORE_W-1:0]   score_q;
  logic [NUM_FOOD-1:0]  target_q;
  logic [NUM_FOOD-1:0]  food_valid_q;
  logic [X_W-1:0]       food_x_q [NUM_FOOD];
  logic [Y_W-1:0]       food_y_q [NUM_FOOD];

  logic                 tick;
  logic                 hit;
  logic [2:0]           hit_idx;
  logic [NUM_FOOD-1:0]  hit_oh;
  logic [X_W-1:0]       cand_x;
  logic [Y_W-1:0]       cand_y;
  logic                 cand_ok;

  // Tick counter is frozen by pause; the LFSR is not, so pausing still scrambles spawns.
  assign tick = !pause && (cnt_q == TickMax);

  always_comb begin
    cnt_d = cnt_q;
    if (!pause) begin
      cnt_d = (cnt_q == TickMax) ? '0 : cnt_q + CntW'(1);
    end
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  // Downward scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int i = int'(NUM_FOOD) - 1; i >= 0; i--) begin
      if (food_valid_q[i] && food_x_q[i] == head_x && food_y_q[i] == head_y) begin
        hit       = 1'b1;
        hit_idx   = 3'(i);
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  assign cand_x = lfsr_q[X_W-1:0];
  assign cand_y = lfsr_q[X_W+Y_W-1:X_W];

  // The target slot is invalid while respawning, so scanning valid slots covers "others".
  always_comb begin
    cand_ok = (cand_x != '0) && (cand_x <= XMax) && (cand_y != '0) && (cand_y <= YMax) &&
              !((cand_x == head_x) && (cand_y == head_y));
    for (int i = 0; i < int'(NUM_FOOD); i++) begin
      if (food_valid_q[i] && food_x_q[i] == cand_x && food_y_q[i] == cand_y) begin
        cand_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      grow_q       <= 1'b0;
      eaten_idx_q  <= '0;
      score_q      <= '0;
      target_q     <= '0;
      food_valid_q <= '1;
      for (int i = 0; i < int'(NUM_FOOD); i++) begin
        food_x_q[i] <= X_W'(INIT_X + 2 * i);
        food_y_q[i] <= Y_W'(INIT_Y);
      end
    end else begin
      grow_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick || pending_q) begin
            pending_q <= 1'b0;
            if (hit) begin
              for (int i = 0; i < int'(NUM_FOOD); i++) begin
                if (hit_oh[i]) food_valid_q[i] <= 1'b0;
              end
              grow_q      <= 1'b1;
              eaten_idx_q <= hit_idx;
              if (score_q != '1) score_q <= score_q + SCORE_W'(1);
              target_q    <= hit_oh;
              state_q     <= StRespawn;
            end
          end
        end
        StRespawn: begin
          if (tick) pending_q <= 1'b1;
          if (cand_ok) begin
            for (int i = 0; i < int'(NUM_FOOD); i++) begin
              if (target_q[i]) begin
                food_x_q[i]     <= cand_x;
                food_y_q[i]     <= cand_y;
                food_valid_q[i] <= 1'b1;
              end
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < int'(NUM_FOOD); g++) begin : g_pack
    assign food_x[g*X_W +: X_W] = food_x_q[g];
    assign food_y[g*Y_W +: Y_W] = food_y_q[g];
  end

  assign food_valid = food_valid_q;
  assign grow       = grow_q;
  assign eaten_idx  = eaten_idx_q;
  assign score      = score_q;

endmodule

// File: tb/tb_food_manager.sv
// Bench for food_manager: a behavioural reference model predicts every eat into a scoreboard
// queue; a negedge monitor pops on each grow pulse and also compares slot state each cycle.
module tb_food_manager;
  localparam int NF = 3;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int TD = 4;
  localparam int GW = 40;
  localparam int GH = 30;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pause = 1'b0;
  logic [XW-1:0]     head_x = '0;
  logic [YW-1:0]     head_y = '0;
  logic [NF*XW-1:0]  food_x;
  logic [NF*YW-1:0]  food_y;
  logic [NF-1:0]     food_valid;
  logic              grow;
  logic [2:0]        eaten_idx;
  logic [9:0]        score;

  food_manager #(.NUM_FOOD(NF), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset     (reset),
    .pause     (pause),
    .head_x    (head_x),
    .head_y    (head_y),
    .food_x    (food_x),
    .food_y    (food_y),
    .food_valid(food_valid),
    .grow      (grow),
    .eaten_idx (eaten_idx),
    .score     (score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int idx; int score;} eat_t;
  eat_t        exp_q[$];
  int          m_cnt;
  logic [15:0] m_lfsr;
  int          mx[NF];
  int          my[NF];
  bit          mv[NF];
  bit          m_resp;
  bit          m_pend;
  int          m_tgt;
  int          m_score;

  always @(posedge clk) begin : ref_model
    int ncnt, nscore, ntgt, cx, cy, win;
    logic [15:0] nl;
    int nx[NF];
    int ny[NF];
    bit nv[NF];
    bit nresp, npend, tk, ok;
    if (!reset) begin
      m_cnt   <= 0;
      m_lfsr  <= 16'hACE1;
      m_resp  <= 1'b0;
      m_pend  <= 1'b0;
      m_tgt   <= 0;
      m_score <= 0;
      for (int i = 0; i < NF; i++) begin
        mx[i] <= 24 + 2 * i;
        my[i] <= 10;
        mv[i] <= 1'b1;
      end
    end else begin
      nx = mx; ny = my; nv = mv;
      nresp = m_resp; npend = m_pend; ntgt = m_tgt; nscore = m_score;
      tk   = !pause && (m_cnt == TD - 1);
      ncnt = pause ? m_cnt : (m_cnt + 1) % TD;
      nl   = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (!m_resp) begin
        if (tk || m_pend) begin
          npend = 1'b0;
          win = -1;
          for (int i = NF - 1; i >= 0; i--)
            if (mv[i] && mx[i] == int'(head_x) && my[i] == int'(head_y)) win = i;
          if (win >= 0) begin
            nv[win] = 1'b0;
            nscore  = (m_score == 1023) ? 1023 : m_score + 1;
            nresp   = 1'b1;
            ntgt    = win;
            exp_q.push_back('{idx: win, score: nscore});
          end
        end
      end else begin
        if (tk) npend = 1'b1;
        cx = int'(m_lfsr[5:0]);
        cy = int'(m_lfsr[10:6]);
        ok = cx >= 1 && cx <= GW - 2 && cy >= 1 && cy <= GH - 2 &&
             !(cx == int'(head_x) && cy == int'(head_y));
        for (int i = 0; i < NF; i++) if (mv[i] && mx[i] == cx && my[i] == cy) ok = 1'b0;
        if (ok) begin
          nx[m_tgt] = cx;
          ny[m_tgt] = cy;
          nv[m_tgt] = 1'b1;
          nresp = 1'b0;
        end
      end
      m_cnt <= ncnt; m_lfsr <= nl; mx <= nx; my <= ny; mv <= nv;
      m_resp <= nresp; m_pend <= npend; m_tgt <= ntgt; m_score <= nscore;
    end
  end

  // ---------------- monitor ----------------
  bit mon_en = 1'b0;
  bit prev_grow = 1'b0;
  int grow_cnt = 0;

  always @(negedge clk) begin : monitor
    eat_t e;
    logic [NF-1:0] vexp;
    if (mon_en) begin
      check("grow_vs_model", {31'd0, grow}, {31'd0, exp_q.size() != 0});
      check("grow_back_to_back", {31'd0, grow & prev_grow}, 32'd0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (grow) begin
          check("eaten_idx", {29'd0, eaten_idx}, e.idx);
          check("eat_score", {22'd0, score}, e.score);
        end
      end
      if (grow) grow_cnt++;
      prev_grow = grow;
      for (int i = 0; i < NF; i++) vexp[i] = mv[i];
      check("food_valid", {29'd0, food_valid}, {29'd0, vexp});
      check("score", {22'd0, score}, m_score);
      for (int i = 0; i < NF; i++) begin
        if (mv[i]) begin
          check("slot_x", {26'd0, food_x[i*XW +: XW]}, mx[i]);
          check("slot_y", {27'd0, food_y[i*YW +: YW]}, my[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int sx(input int i);
    return int'(food_x[i*XW +: XW]);
  endfunction
  function automatic int sy(input int i);
    return int'(food_y[i*YW +: YW]);
  endfunction

  task automatic put_head(input int x, input int y);
    head_x = XW'(x);
    head_y = YW'(y);
  endtask

  task automatic wait_grow(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (grow) got = 1'b1;
    end
  endtask

  task automatic wait_all_valid(input int budget, output bit got);
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (food_valid == 3'b111) got = 1'b1;
    end
  endtask

  task automatic check_init(input string tag);
    check({tag, "_x"}, {14'd0, food_x}, {14'd0, 6'd28, 6'd26, 6'd24});
    check({tag, "_y"}, {17'd0, food_y}, {17'd0, 5'd10, 5'd10, 5'd10});
    check({tag, "_valid"}, {29'd0, food_valid}, 32'd7);
    check({tag, "_score"}, {22'd0, score}, 32'd0);
    check({tag, "_grow"}, {31'd0, grow}, 32'd0);
  endtask

  initial begin : stim
    bit got;
    int g0, cyc, pick;
    logic inb;
    reset = 1'b0;
    put_head(0, 0);
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check_init("reset");
    reset = 1'b1;

    // Head parked off-field: nothing may be eaten over 20 ticks.
    repeat (20 * TD) @(negedge clk);
    check("idle_grow_count", grow_cnt, 32'd0);
    check("idle_score", {22'd0, score}, 32'd0);

    // Eat slot 1.
    put_head(26, 10);
    wait_grow(TD + 2, got);
    check("eat1_seen", {31'd0, got}, 32'd1);
    check("eat1_valid", {29'd0, food_valid}, 32'd5);
    check("eat1_idx", {29'd0, eaten_idx}, 32'd1);
    check("eat1_score", {22'd0, score}, 32'd1);
    wait_all_valid(300, got);
    check("respawn1_done", {31'd0, got}, 32'd1);
    inb = sx(1) >= 1 && sx(1) <= GW - 2 && sy(1) >= 1 && sy(1) <= GH - 2;
    check("respawn1_inbounds", {31'd0, inb}, 32'd1);
    check("respawn1_not_head", {31'd0, sx(1) == 26 && sy(1) == 10}, 32'd0);
    check("respawn1_not_s0", {31'd0, sx(1) == 24 && sy(1) == 10}, 32'd0);
    check("respawn1_not_s2", {31'd0, sx(1) == 28 && sy(1) == 10}, 32'd0);

    // Pause with head on food: no eat, then eat on the next tick after release.
    put_head(sx(0), sy(0));
    pause = 1'b1;
    g0 = grow_cnt;
    repeat (50) @(negedge clk);
    check("pause_no_grow", grow_cnt - g0, 32'd0);
    pause = 1'b0;
    wait_grow(TD + 1, got);
    check("unpause_eat", {31'd0, got}, 32'd1);
    check("unpause_idx", {29'd0, eaten_idx}, 32'd0);

    // Chase food until the score saturates; hopping head onto slots exercises pending ticks.
    cyc = 0;
    while (score != 10'h3FF && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      pick = -1;
      for (int i = NF - 1; i >= 0; i--) if (food_valid[i]) pick = i;
      if (pick >= 0) put_head(sx(pick), sy(pick));
    end
    check("score_reached_max", {22'd0, score}, 32'd1023);
    put_head(0, 0);
    wait_all_valid(300, got);
    put_head(sx(0), sy(0));
    wait_grow(TD + 2, got);
    check("sat_eat_seen", {31'd0, got}, 32'd1);
    check("sat_idx", {29'd0, eaten_idx}, 32'd0);
    check("sat_score", {22'd0, score}, 32'd1023);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      pick = int'($urandom_range(0, 99));
      pause = (pick < 8);
      if (pick % 3 == 0) begin
        g0 = int'($urandom_range(0, NF - 1));
        put_head(sx(g0), sy(g0));
      end else if (pick % 7 == 0) begin
        put_head(int'($urandom_range(0, GW - 1)), int'($urandom_range(0, GH - 1)));
      end
    end
    pause = 1'b0;

    // Reset while a respawn is in flight.
    put_head(0, 0);
    wait_all_valid(300, got);
    put_head(sx(2), sy(2));
    wait_grow(TD + 2, got);
    check("pre_reset_eat", {31'd0, got}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_init("mid_respawn_reset");
    reset = 1'b1;
    put_head(0, 0);
    repeat (4 * TD) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/food_manager.md
FOOD_MANAGER -- requirements
Module: food_manager

Interface
REQ-001 Parameter NUM_FOOD, default 3: number of food slots, legal 1..8.
REQ-002 Parameter X_W, default 6; Y_W, default 5: coordinate widths, X_W+Y_W <= 16.
REQ-003 Parameter GRID_W, default 40; GRID_H, default 30: playfield size in cells, border cells are wall.
REQ-004 Parameter TICK_DIV, default 250000: clk cycles per evaluation tick, >= 2.
REQ-005 Parameter INIT_X, default 24; INIT_Y, default 10: reset position of slot 0.
REQ-006 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value, nonzero.
REQ-007 Parameter SCORE_W, default 10: score counter width.
REQ-008 clk  in  1  clock, all state updates on rising edge.
REQ-009 reset  in  1  synchronous, active-low.
REQ-010 pause  in  1  high holds the tick counter; the LFSR keeps running.
REQ-011 head_x  in  X_W  snake head column.
REQ-012 head_y  in  Y_W  snake head row.
REQ-013 food_x  out  NUM_FOOD*X_W  flattened, slot i at bits [i*X_W +: X_W].
REQ-014 food_y  out  NUM_FOOD*Y_W  flattened, slot i at bits [i*Y_W +: Y_W].
REQ-015 food_valid  out  NUM_FOOD  slot i is present on the field.
REQ-016 grow  out  1  one-cycle pulse per food eaten.
REQ-017 eaten_idx  out  3  index of the last eaten slot.
REQ-018 score  out  SCORE_W  count of foods eaten.

Function
REQ-019 Tick counter counts 0..TICK_DIV-1 while pause=0, wraps to 0; tick asserts for the one cycle in which the count equals TICK_DIV-1.
REQ-020 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk, including during pause.
REQ-021 FSM states: IDLE, RESPAWN.
REQ-022 IDLE, on tick or pending=1: compare head to every valid slot; lowest-index match i wins; clear food_valid[i]; grow=1 next cycle; eaten_idx=i; score+1, saturating at all-ones; clear pending; go to RESPAWN with target i.
REQ-023 IDLE, tick with no match: no output change.
REQ-024 RESPAWN, each cycle: candidate cx=lfsr[X_W-1:0], cy=lfsr[X_W+Y_W-1:X_W].
REQ-025 Candidate is accepted only if 1<=cx<=GRID_W-2, 1<=cy<=GRID_H-2, (cx,cy)!=(head_x,head_y), and it differs from every other valid slot.
REQ-026 On accept: write target slot, set food_valid[target]=1 in the same edge, return to IDLE.
REQ-027 On reject: stay in RESPAWN; outputs unchanged.
REQ-028 Tick arriving while in RESPAWN sets pending=1 and is serviced on the first IDLE cycle; multiple ticks collapse into one pending.
REQ-029 grow is high for exactly one cycle per eat and is never high two cycles in a row.
REQ-030 Valid slots always hold pairwise-distinct, in-bounds, non-wall coordinates.
REQ-031 Combinational compare, no multi-cycle arithmetic; RESPAWN exit latency is data-dependent, one cycle minimum.

Reset
REQ-032 While reset=0 on an edge: counter=0; LFSR=LFSR_SEED; FSM=IDLE; pending=0; grow=0; eaten_idx=0; score=0.
REQ-033 While reset=0 on an edge, slot i is set to (INIT_X+2*i, INIT_Y) with food_valid all ones.
REQ-034 Reset asserted during RESPAWN abandons the respawn; reset values apply on that edge.

Verification (NUM_FOOD=3, TICK_DIV=4, other defaults)
REQ-035 Release reset, head=(0,0) -> slots (24,10),(26,10),(28,10) all valid; grow never asserts over 20 ticks; score=0.
REQ-036 head=(26,10) at tick -> next cycle food_valid=3'b101, grow one-cycle pulse, eaten_idx=1, score=1; slot 1 later revalid at in-bounds cell distinct from (24,10),(28,10),(26,10).
REQ-037 Force score to 1023 and eat slot 0 -> score stays 1023, grow still pulses.
REQ-038 Hold head on a respawning slot with a tick during RESPAWN -> pending serviced on first IDLE cycle, exactly one grow per eat.
REQ-039 pause=1 for 50 cycles with head on food -> no grow, counter frozen; release -> eat on next tick.
REQ-040 Assert reset mid-RESPAWN -> next cycle all slots back at initial coordinates, valid=3'b111, score=0, grow=0.
